// File: rtl/alu_op_decoder.sv
// Registered RISC-V decode stage feeding the ALU.
// Takes instruction words over a valid/ready handshake and holds one decoded
// bundle at a time in an output register. That register supports backpressure
// and flush. A saturating counter records how many illegal words were accepted.
module alu_op_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0]      inst_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [3:0]       ALU_Operation_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [4:0]       rd_o,
    output logic [31:0]      imm_o,
    output logic             alu_src_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_ORI = 4'b1000;
    localparam logic [3:0] ALU_LUI = 4'b1001;
    localparam logic [3:0] ALU_SW  = 4'b1100;
    localparam logic [3:0] ALU_LW  = 4'b1101;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i_sx;
    logic [31:0] imm_s_sx;
    logic [31:0] imm_shamt;

    assign opcode    = inst_i[6:0];
    assign funct3    = inst_i[14:12];
    assign funct7    = inst_i[31:25];
    assign imm_i_sx  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_sx  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_shamt = {27'd0, inst_i[24:20]};

    logic [3:0]  dec_alu;
    logic [31:0] dec_imm;
    logic        dec_src;
    logic        dec_rw;
    logic        dec_mr;
    logic        dec_mw;
    logic        dec_ill;

    // Combinational decode of the incoming word into a bundle
    always_comb begin
        dec_alu = ALU_ADD;
        dec_imm = 32'd0;
        dec_src = 1'b0;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OP_R: begin
                dec_rw = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec_alu = ALU_ADD;
                        else if (funct7 == 7'b0100000) dec_alu = ALU_SUB;
                        else                           dec_ill = 1'b1;
                    end
                    3'b100:  dec_ill = (funct7 != 7'd0);
                    3'b110:  dec_ill = (funct7 != 7'd0);
                    3'b111:  dec_ill = (funct7 != 7'd0);
                    3'b001:  dec_ill = (funct7 != 7'd0);
                    3'b101:  dec_ill = (funct7 != 7'd0);
                    default: dec_ill = 1'b1;
                endcase
                case (funct3)
                    3'b100:  dec_alu = ALU_XOR;
                    3'b110:  dec_alu = ALU_OR;
                    3'b111:  dec_alu = ALU_AND;
                    3'b001:  dec_alu = ALU_SLL;
                    3'b101:  dec_alu = ALU_SRL;
                    default: ;
                endcase
            end
            OP_I: begin
                dec_src = 1'b1;
                dec_rw  = 1'b1;
                dec_imm = imm_i_sx;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_ORI;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        dec_imm = imm_shamt;
                        dec_ill = (funct7 != 7'd0);
                    end
                    3'b101: begin
                        dec_alu = ALU_SRL;
                        dec_imm = imm_shamt;
                        dec_ill = (funct7 != 7'd0);
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec_alu = ALU_LUI;
                dec_src = 1'b1;
                dec_rw  = 1'b1;
                // The ALU applies the <<12, so the raw upper field is passed
                dec_imm = {12'd0, inst_i[31:12]};
            end
            OP_LOAD: begin
                dec_alu = ALU_LW;
                dec_src = 1'b1;
                dec_rw  = 1'b1;
                dec_mr  = 1'b1;
                dec_imm = imm_i_sx;
                dec_ill = (funct3 != 3'b010);
            end
            OP_STOR: begin
                dec_alu = ALU_SW;
                dec_src = 1'b1;
                dec_mw  = 1'b1;
                dec_imm = imm_s_sx;
                dec_ill = (funct3 != 3'b010);
            end
            default: dec_ill = 1'b1;
        endcase
        // An illegal bundle carries no controls, only the raw register fields
        if (dec_ill) begin
            dec_alu = ALU_ADD;
            dec_imm = 32'd0;
            dec_src = 1'b0;
            dec_rw  = 1'b0;
            dec_mr  = 1'b0;
            dec_mw  = 1'b0;
        end
    end

    logic             valid_q, valid_d;
    logic [3:0]       alu_q, alu_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0]      imm_q, imm_d;
    logic             src_q, src_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign inst_ready_o = !reset && (!valid_q || dec_ready_i);
    assign accept       = inst_valid_i && inst_ready_o && !flush_i;

    // Next-state for the output register, the valid bit and the counter
    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        src_d   = src_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        mw_d    = mw_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            alu_d   = dec_alu;
            rs1_d   = inst_i[19:15];
            rs2_d   = inst_i[24:20];
            rd_d    = inst_i[11:7];
            imm_d   = dec_imm;
            src_d   = dec_src;
            rw_d    = dec_rw;
            mr_d    = dec_mr;
            mw_d    = dec_mw;
            ill_d   = dec_ill;
            if (dec_ill && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register and counter with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= 4'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            imm_q   <= 32'd0;
            src_q   <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            src_q   <= src_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dec_valid_o     = valid_q && !reset;
    assign ALU_Operation_o = alu_q;
    assign rs1_o           = rs1_q;
    assign rs2_o           = rs2_q;
    assign rd_o            = rd_q;
    assign imm_o           = imm_q;
    assign alu_src_o       = src_q;
    assign reg_write_o     = rw_q;
    assign mem_read_o      = mr_q;
    assign mem_write_o     = mw_q;
    assign illegal_o       = ill_q;
    assign illegal_cnt_o   = cnt_q;

endmodule
